// File: rtl/mvu_dbank_reader.sv
// mvu_dbank_reader: strided read-back engine for an MVU data bank with a credit-protected output FIFO.
// Optional build: define MVU_DBRD_WRAPCHK_EN to build the sticky address-wrap flag err_wrap.
module mvu_dbank_reader #(
    parameter int BDBANKA      = 15,
    parameter int BDBANKW      = 64,
    parameter int BLENGTH      = 15,
    parameter int BJUMP        = 15,
    parameter int MEMRDLATENCY = 2,
    parameter int FIFODEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BDBANKA-1:0] baddr,
    input  logic [BLENGTH-1:0] length,
    input  logic [BJUMP-1:0]   jump,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [BDBANKA-1:0] rd_addr,
    input  logic [BDBANKW-1:0] rd_data,
    output logic               m_valid,
    output logic [BDBANKW-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               err_wrap,
    output logic [1:0]         dbg_state
);
    localparam int CW = $clog2(FIFODEPTH + 1);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int LW = $clog2(MEMRDLATENCY + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state;
    logic [BDBANKA-1:0]      addr;
    logic [BDBANKA-1:0]      next_addr;
    logic [BJUMP-1:0]        jump_q;
    logic [BLENGTH-1:0]      remaining;
    logic [MEMRDLATENCY-1:0] sr_v;
    logic [MEMRDLATENCY-1:0] sr_last;
    logic [BDBANKW:0]        fifo_mem [FIFODEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [LW-1:0]           inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    head_last;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEMRDLATENCY; i++) inflight = inflight + LW'(sr_v[i]);
    end

    // A read is only issued when a FIFO slot is already reserved for its return word.
    assign issue = (state == ISSUE) && (remaining != '0) &&
                   ((int'(inflight) + int'(count)) < FIFODEPTH);
    assign push  = sr_v[MEMRDLATENCY-1];

    // Stream handshake: a word transfers on any cycle with m_valid && m_ready;
    // while m_valid && !m_ready the head word and its m_last are held unchanged.
    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign head_last = fifo_mem[rd_ptr][BDBANKW];
    assign m_data    = m_valid ? fifo_mem[rd_ptr][BDBANKW-1:0] : '0;
    assign m_last    = m_valid && head_last;
    assign rd_en     = issue;
    assign rd_addr   = addr;
    assign dbg_state = state;

`ifdef MVU_DBRD_WRAPCHK_EN
    logic [BDBANKA:0] addr_sum;
    logic             wrap;
    // The extra top bit is set exactly when the signed step leaves [0, 2^BDBANKA).
    assign addr_sum  = {1'b0, addr} + (BDBANKA+1)'(signed'(jump_q));
    assign next_addr = addr_sum[BDBANKA-1:0];
    assign wrap      = addr_sum[BDBANKA];

    always_ff @(posedge clk) begin
        if (rst)                        err_wrap <= 1'b0;
        else if (state == IDLE && start) err_wrap <= 1'b0;
        else if (issue && wrap)          err_wrap <= 1'b1;
    end
`else
    assign next_addr = addr + BDBANKA'(signed'(jump_q));
    assign err_wrap  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            jump_q    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= baddr;
                        jump_q    <= jump;
                        remaining <= length;
                        if (length != '0) begin
                            busy  <= 1'b1;
                            state <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= next_addr;
                        remaining <= remaining - BLENGTH'(1);
                        if (remaining == BLENGTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return-data tracking and FIFO pointers; clearing these on reset drops any in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_v    <= '0;
            sr_last <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            sr_v    <= (sr_v << 1) | MEMRDLATENCY'(issue);
            sr_last <= (sr_last << 1) | MEMRDLATENCY'(issue && (remaining == BLENGTH'(1)));
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {sr_last[MEMRDLATENCY-1], rd_data};
    end
endmodule

// File: tb/tb_mvu_dbank_reader.sv
// Directed-vector bench for mvu_dbank_reader with a two-cycle-latency bank model and a scoreboard.
module tb_mvu_dbank_reader;
    localparam int A     = 15;
    localparam int W     = 64;
    localparam int LEN   = 15;
    localparam int J     = 15;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [A-1:0]   baddr;
    logic [LEN-1:0] length;
    logic [J-1:0]   jump;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [A-1:0]   rd_addr;
    logic [W-1:0]   rd_data;
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_ready;
    logic           err_wrap;
    logic [1:0]     dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_start;
    int mvalid_cnt;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [A-1:0] pa1 = '0;
    logic [A-1:0] pa2 = '0;

    logic [A-1:0] exp_addr[$];
    logic [W-1:0] exp_q[$];
    logic [A-1:0] rd_log[$];
    int           rd_cyc[$];
    logic [W-1:0] got_q[$];
    logic         got_last[$];
    int           got_cyc[$];
    int           done_cyc[$];

    mvu_dbank_reader dut (
        .clk(clk), .rst(rst), .start(start), .baddr(baddr), .length(length), .jump(jump),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .err_wrap(err_wrap), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] word_of(input logic [A-1:0] a);
        return {16'hC0DE, 2'b00, ~a, 16'h0000, a};
    endfunction

    // Bank model: data for the address strobed in cycle c is presented in cycle c+2.
    always @(posedge clk) begin
        pa1 <= rd_addr;
        pa2 <= pa1;
    end
    assign rd_data = word_of(pa2);

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                rd_log.push_back(rd_addr);
                rd_cyc.push_back(cyc);
            end
            if (m_valid) mvalid_cnt++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (m_valid && !m_ready) begin
                if (prev_stall) check("stall_hold", m_data, prev_data);
                prev_stall = 1'b1;
                prev_data  = m_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic clear_logs();
        exp_addr.delete(); exp_q.delete();
        rd_log.delete(); rd_cyc.delete();
        got_q.delete(); got_last.delete(); got_cyc.delete(); done_cyc.delete();
        mvalid_cnt = 0;
        prev_stall = 1'b0;
    endtask

    task automatic expect_cmd(input logic [A-1:0] b, input int n, input logic [J-1:0] j);
        logic [A-1:0] a;
        a = b;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a);
            exp_q.push_back(word_of(a));
            a = a + j;
        end
    endtask

    task automatic drive_start(input logic [A-1:0] b, input logic [LEN-1:0] n, input logic [J-1:0] j);
        @(posedge clk); #1;
        start = 1'b1; baddr = b; length = n; jump = j;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cyc.size() == 0) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard comparison of one finished command
    task automatic compare_cmd(input string name);
        check({name, "_nrd"}, rd_log.size(), exp_addr.size());
        for (int i = 0; i < rd_log.size() && i < exp_addr.size(); i++)
            check({name, "_rdaddr"}, rd_log[i], exp_addr[i]);
        check({name, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({name, "_data"}, got_q[i], exp_q[i]);
            check({name, "_last"}, got_last[i], (i == exp_q.size() - 1));
        end
        check({name, "_ndone"}, done_cyc.size(), 1);
        if (got_cyc.size() > 0 && done_cyc.size() > 0)
            check({name, "_done_cyc"}, done_cyc[0], got_cyc[got_cyc.size()-1] + 1);
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; baddr = '0; length = '0; jump = '0; m_ready = 1'b1;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_err_wrap", err_wrap, 0);
        rst = 1'b0;

        // Basic 4-word read, with a start pulse during the command that must be ignored
        clear_logs();
        expect_cmd(15'h0010, 4, 15'h0001);
        drive_start(15'h0010, 15'd4, 15'h0001);
        check("t1_busy", busy, 1);
        start = 1'b1; baddr = 15'h0500; length = 15'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        compare_cmd("t1");
        if (rd_cyc.size() == 4) begin
            check("t1_first_rd_cyc", rd_cyc[0], t_start + 1);
            check("t1_last_rd_cyc", rd_cyc[3], t_start + 4);
        end else check("t1_rd_cyc_count", rd_cyc.size(), 4);
        if (got_cyc.size() > 0) check("t1_first_valid_cyc", got_cyc[0], t_start + 4);
        check("t1_mvalid_cycles", mvalid_cnt, 4);

        // Zero-length command
        clear_logs();
        drive_start(15'h0020, 15'd0, 15'h0001);
        wait_done(50);
        compare_cmd("t2");
        if (done_cyc.size() > 0) check("t2_done_cyc", done_cyc[0], t_start + 1);
        check("t2_mvalid", mvalid_cnt, 0);

        // Negative stride
        clear_logs();
        expect_cmd(15'h0100, 3, 15'h7FFE);
        drive_start(15'h0100, 15'd3, 15'h7FFE);
        wait_done(200);
        compare_cmd("t3");

        // Backpressure: credit limit stalls issue at FIFODEPTH reads
        clear_logs();
        m_ready = 1'b0;
        expect_cmd(15'h0200, 8, 15'h0001);
        drive_start(15'h0200, 15'd8, 15'h0001);
        repeat (9) @(posedge clk);
        #1;
        check("t4_reads_before_ready", rd_log.size(), DEPTH);
        check("t4_stall_valid", m_valid, 1);
        check("t4_stall_head", m_data, word_of(15'h0200));
        m_ready = 1'b1;
        wait_done(200);
        compare_cmd("t4");

        // Address overflow wrap
        clear_logs();
        expect_cmd(15'h7FFF, 2, 15'h0001);
        drive_start(15'h7FFF, 15'd2, 15'h0001);
        wait_done(200);
        compare_cmd("t5");
`ifdef MVU_DBRD_WRAPCHK_EN
        check("t5_err_wrap", err_wrap, 1);
`else
        check("t5_err_wrap", err_wrap, 0);
`endif

        // Address underflow wrap
        clear_logs();
        expect_cmd(15'h0000, 2, 15'h7FFF);
        drive_start(15'h0000, 15'd2, 15'h7FFF);
        wait_done(200);
        compare_cmd("t6");
`ifdef MVU_DBRD_WRAPCHK_EN
        check("t6_err_wrap", err_wrap, 1);
`else
        check("t6_err_wrap", err_wrap, 0);
`endif

        // Reset in the middle of a command, then a clean command
        clear_logs();
        drive_start(15'h0300, 15'd6, 15'h0001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        check("t7_rd_en", rd_en, 0);
        check("t7_rd_addr", rd_addr, 0);
        check("t7_m_valid", m_valid, 0);
        check("t7_m_data", m_data, 0);
        check("t7_m_last", m_last, 0);
        check("t7_err_wrap", err_wrap, 0);
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("t7_no_stale_valid", mvalid_cnt, 0);
        check("t7_no_reads", rd_log.size(), 0);
        clear_logs();
        expect_cmd(15'h0040, 5, 15'h0003);
        drive_start(15'h0040, 15'd5, 15'h0003);
        wait_done(200);
        compare_cmd("t8");
        check("t8_err_wrap", err_wrap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
